mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 144 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: each MMIO write strobe queues one byte in a
// small FIFO, and an 8N1 serializer drains the FIFO back-to-back.
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mmio_wea,
  input  logic [31:0] mmio_dat,
  output logic        tx,
  output logic        mmio_read,
  output logic        fifo_full,
  output logic        tx_busy,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          mmio_read_q, mmio_read_d;
  logic          overflow_q, overflow_d;
  logic          baud_end, pop, push;

  // Only the low byte is transmitted; the upper bits are deliberately dropped.
  logic unused_dat;
  assign unused_dat = ^mmio_dat[31:8];

  always_comb begin
    baud_end = (baud_q == BAUD_LAST);
    pop      = (count_q != '0) && ((state_q == IDLE) || (state_q == STOP && baud_end));
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    push     = mmio_wea && ((count_q != DEPTH_C) || pop);

    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + 16'd1;
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + 16'd1;
        if (baud_end) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      default: begin
        baud_d = baud_q + 16'd1;
        if (baud_end) begin
          baud_d = '0;
          if (pop) begin
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase

    // Line level follows the state being entered so tx stays a pure flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
    mmio_read_d = push;
    overflow_d  = overflow_q | (mmio_wea & ~push);
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mmio_read_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mmio_read_q <= mmio_read_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage has no reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && !Rst) mem_q[wr_ptr_q] <= mmio_dat[7:0];
  end

  assign tx        = tx_q;
  assign mmio_read = mmio_read_q;
  assign overflow  = overflow_q;
  assign fifo_full = (count_q == DEPTH_C);
  assign tx_busy   = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with 4 clocks per bit and a 4-entry FIFO;
// the serial line is checked cycle by cycle against hand-built 8N1 frames.
module tb_mmio_uart_tx;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mmio_wea = 1'b0;
  logic [31:0] mmio_dat = '0;
  logic        tx, mmio_read, fifo_full, tx_busy, overflow;

  int passed = 0;
  int total  = 0;

  mmio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .Rst       (Rst),
    .mmio_wea  (mmio_wea),
    .mmio_dat  (mmio_dat),
    .tx        (tx),
    .mmio_read (mmio_read),
    .fifo_full (fifo_full),
    .tx_busy   (tx_busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // One write strobe across the next rising edge; ack is visible afterwards.
  task automatic wr(input logic [31:0] d, input logic exp_ack, input string tag);
    mmio_wea = 1'b1;
    mmio_dat = d;
    @(negedge clk);
    mmio_wea = 1'b0;
    chk(tag, mmio_read, exp_ack);
    $display("write %h -> mmio_read=%b fifo_full=%b overflow=%b", d, mmio_read, fifo_full, overflow);
  endtask

  // Checks frame cycles first..last (0..39), sampling at each falling edge.
  task automatic frame(input logic [7:0] b, input int first, input int last, input string tag);
    logic exp;
    int   k;
    for (int i = first; i <= last; i++) begin
      k = i / 4;
      if (k == 0)      exp = 1'b0;
      else if (k == 9) exp = 1'b1;
      else             exp = b[k-1];
      chk($sformatf("%s byte %h cyc %0d", tag, b, i), tx, exp);
      @(negedge clk);
    end
    $display("frame %h checked cycles %0d..%0d", b, first, last);
  endtask

  task automatic idle_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s tx cyc %0d", tag, i), tx, 1'b1);
      @(negedge clk);
    end
    chk({tag, " busy"}, tx_busy, 1'b0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst tx", tx, 1'b1);
    chk("rst mmio_read", mmio_read, 1'b0);
    chk("rst fifo_full", fifo_full, 1'b0);
    chk("rst tx_busy", tx_busy, 1'b0);
    chk("rst overflow", overflow, 1'b0);
    Rst = 1'b0;
    @(negedge clk);

    // Single byte, two-edge start latency
    wr(32'h0000_00A5, 1'b1, "a5 ack");
    chk("a5 tx before start", tx, 1'b1);
    chk("a5 busy", tx_busy, 1'b1);
    @(negedge clk);
    chk("a5 ack one cycle", mmio_read, 1'b0);
    frame(8'hA5, 0, 39, "a5");
    chk("a5 busy after stop", tx_busy, 1'b0);
    chk("a5 idle tx", tx, 1'b1);

    // Back-to-back frames with no gap
    wr(32'h55, 1'b1, "b2b 55 ack");
    wr(32'h0F, 1'b1, "b2b 0f ack");
    frame(8'h55, 0, 39, "b2b");
    frame(8'h0F, 0, 39, "b2b");
    chk("b2b busy after", tx_busy, 1'b0);

    // Upper data bits ignored
    wr(32'hDEAD_BE3C, 1'b1, "upper ack");
    @(negedge clk);
    frame(8'h3C, 0, 39, "upper");

    // Overflow burst: 0x06 is dropped while the FIFO is full
    wr(32'h01, 1'b1, "ovf 01 ack");
    wr(32'h02, 1'b1, "ovf 02 ack");
    wr(32'h03, 1'b1, "ovf 03 ack");
    wr(32'h04, 1'b1, "ovf 04 ack");
    wr(32'h05, 1'b1, "ovf 05 ack");
    chk("ovf full", fifo_full, 1'b1);
    chk("ovf flag clear before drop", overflow, 1'b0);
    wr(32'h06, 1'b0, "ovf 06 dropped");
    chk("ovf flag", overflow, 1'b1);
    chk("ovf still full", fifo_full, 1'b1);
    frame(8'h01, 4, 39, "ovf");
    frame(8'h02, 0, 39, "ovf");
    frame(8'h03, 0, 39, "ovf");
    frame(8'h04, 0, 39, "ovf");
    frame(8'h05, 0, 39, "ovf");
    idle_quiet(20, "ovf no 06");
    chk("ovf sticky", overflow, 1'b1);

    // Reset during DATA bit 3 of 0xFF with two bytes queued; write on reset edge dropped
    wr(32'hFF, 1'b1, "rst ff ack");
    wr(32'hAA, 1'b1, "rst aa ack");
    wr(32'hBB, 1'b1, "rst bb ack");
    frame(8'hFF, 1, 16, "rst");
    Rst = 1'b1;
    mmio_wea = 1'b1;
    mmio_dat = 32'h99;
    @(negedge clk);
    mmio_wea = 1'b0;
    Rst = 1'b0;
    chk("rst mid tx", tx, 1'b1);
    chk("rst mid busy", tx_busy, 1'b0);
    chk("rst mid overflow", overflow, 1'b0);
    chk("rst mid full", fifo_full, 1'b0);
    chk("rst mid write dropped", mmio_read, 1'b0);
    $display("reset mid-frame: tx=%b busy=%b overflow=%b", tx, tx_busy, overflow);
    idle_quiet(60, "rst quiet");

    // Full FIFO accepts a write on the edge that pops at STOP end
    wr(32'h11, 1'b1, "pp 11 ack");
    wr(32'h22, 1'b1, "pp 22 ack");
    wr(32'h33, 1'b1, "pp 33 ack");
    wr(32'h44, 1'b1, "pp 44 ack");
    wr(32'h55, 1'b1, "pp 55 ack");
    chk("pp full", fifo_full, 1'b1);
    frame(8'h11, 3, 38, "pp");
    chk("pp stop tx", tx, 1'b1);
    chk("pp full at stop", fifo_full, 1'b1);
    wr(32'h77, 1'b1, "pp 77 ack");
    chk("pp count kept", fifo_full, 1'b1);
    chk("pp no overflow", overflow, 1'b0);
    frame(8'h22, 0, 39, "pp");
    frame(8'h33, 0, 39, "pp");
    frame(8'h44, 0, 39, "pp");
    frame(8'h55, 0, 39, "pp");
    frame(8'h77, 0, 39, "pp");
    idle_quiet(10, "pp end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
